// File: rtl/dmg_timer_ctl.sv
`default_nettype none
// ============================================================================
// Module   : dmg_timer_ctl
// Brief    : DMG divider/timer control. Owns DIV/TIMA/TMA/TAC (FF04-FF07),
//            the falling-edge TIMA increment and the overflow/reload/irq sequence.
// Revision : 1.0 - initial release
// ============================================================================
module dmg_timer_ctl #(
    parameter int DIV_W        = 16,
    parameter int RELOAD_DELAY = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       cpu_sel_i,
    input  logic [1:0] cpu_a_i,
    input  logic       cpu_wr_i,
    input  logic [7:0] cpu_wdata_i,
    output logic [7:0] cpu_rdata_o,
    output logic       irq_timer_o,
    output logic [3:0] div_tap_o
);

    localparam int               CNT_W    = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELOAD_DELAY - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OVF    = 2'd1;
    localparam logic [1:0] S_RELOAD = 2'd2;

    logic [DIV_W-1:0] div_q,   div_d;
    logic [7:0]       tima_q,  tima_d;
    logic [7:0]       tma_q,   tma_d;
    logic [2:0]       tac_q,   tac_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       state_q, state_d;
    logic             tap_q;

    logic w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
    logic w_sel_bit, w_tap, w_inc;

    assign w_wr_div  = cpu_sel_i & cpu_wr_i & (cpu_a_i == 2'd0);
    assign w_wr_tima = cpu_sel_i & cpu_wr_i & (cpu_a_i == 2'd1);
    assign w_wr_tma  = cpu_sel_i & cpu_wr_i & (cpu_a_i == 2'd2);
    assign w_wr_tac  = cpu_sel_i & cpu_wr_i & (cpu_a_i == 2'd3);

    assign div_d = w_wr_div ? '0 : div_q + DIV_W'(1);
    assign tma_d = w_wr_tma ? cpu_wdata_i : tma_q;
    assign tac_d = w_wr_tac ? cpu_wdata_i[2:0] : tac_q;

    always_comb begin
        w_sel_bit = div_q[9];
        case (tac_q[1:0])
            2'b00:   w_sel_bit = div_q[9];
            2'b01:   w_sel_bit = div_q[3];
            2'b10:   w_sel_bit = div_q[5];
            default: w_sel_bit = div_q[7];
        endcase
    end

    // Disabling the timer or moving the tap can also produce a falling edge;
    // that spurious increment is deliberate hardware-compatible behaviour.
    assign w_tap = tac_q[2] & w_sel_bit;
    assign w_inc = tap_q & ~w_tap;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_q  <= '0;
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'b000;
            cnt_q  <= '0;
            tap_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            cnt_q  <= cnt_d;
            tap_q  <= w_tap;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // TMA is copied on entry to RELOAD so TIMA already shows it during the irq clk.
    always_comb begin
        state_d = state_q;
        tima_d  = tima_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_wr_tima) begin
                    tima_d = cpu_wdata_i;
                end else if (w_inc) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        cnt_d   = CNT_INIT;
                        state_d = S_OVF;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            S_OVF: begin
                if (w_wr_tima) begin
                    tima_d  = cpu_wdata_i;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    tima_d  = tma_q;
                    state_d = S_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RELOAD: begin
                if (w_wr_tma) begin
                    tima_d = cpu_wdata_i;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        irq_timer_o = (state_q == S_RELOAD);
    end

    always_comb begin
        cpu_rdata_o = div_q[DIV_W-1:DIV_W-8];
        case (cpu_a_i)
            2'd0:    cpu_rdata_o = div_q[DIV_W-1:DIV_W-8];
            2'd1:    cpu_rdata_o = tima_q;
            2'd2:    cpu_rdata_o = tma_q;
            default: cpu_rdata_o = {5'b11111, tac_q};
        endcase
    end

    assign div_tap_o = {div_q[9], div_q[7], div_q[5], div_q[3]};

endmodule
`default_nettype wire

// File: tb/tb_dmg_timer_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmg_timer_ctl
// Brief    : Directed self-checking bench for dmg_timer_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmg_timer_ctl;

    logic       clk;
    logic       nreset;
    logic       cpu_sel;
    logic [1:0] cpu_a;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       irq_timer;
    logic [3:0] div_tap;

    int total = 0;
    int bad   = 0;

    dmg_timer_ctl #(.DIV_W(16), .RELOAD_DELAY(4)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .cpu_sel_i   (cpu_sel),
        .cpu_a_i     (cpu_a),
        .cpu_wr_i    (cpu_wr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .irq_timer_o (irq_timer),
        .div_tap_o   (div_tap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nk below means "k-th falling edge after reset release"; div == k there.
    task automatic do_reset();
        nreset = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_a = 2'd0; cpu_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_a = a; cpu_wdata = d;
        @(negedge clk);
        cpu_sel = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
        cpu_a = a;
        #1;
        d = cpu_rdata;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // tma=AB, tima=FF, tac=05; returns at N3, overflow edge lands at P17
    task automatic setup_overflow();
        do_reset();
        wr_reg(2'd2, 8'hAB);
        wr_reg(2'd1, 8'hFF);
        wr_reg(2'd3, 8'h05);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        wr_reg(2'd2, 8'h55);
        wr_reg(2'd1, 8'h66);
        wr_reg(2'd3, 8'h07);
        step(700);
        nreset = 1'b0;
        #1;
        rd_reg(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_div got=%h exp=00", d); end
        rd_reg(2'd1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_tima got=%h exp=00", d); end
        rd_reg(2'd2, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_tma got=%h exp=00", d); end
        rd_reg(2'd3, d);
        total++; if (d !== 8'hF8) begin bad++; $display("FAIL reset_tac got=%h exp=F8", d); end
        total++; if (div_tap !== 4'b0000) begin bad++; $display("FAIL reset_tap got=%b exp=0000", div_tap); end
        total++; if (irq_timer !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_timer); end
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_count();
        logic [7:0] d;
        do_reset();
        wr_reg(2'd3, 8'h05);
        rd_reg(2'd3, d);
        total++; if (d !== 8'hFD) begin bad++; $display("FAIL cnt_tac got=%h exp=FD", d); end
        step(15);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL cnt_n16 got=%h exp=00", d); end
        step(1);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL cnt_n17 got=%h exp=01", d); end
        step(32);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL cnt_n49 got=%h exp=03", d); end
        step(206);
        rd_reg(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL cnt_div255 got=%h exp=00", d); end
        step(1);
        rd_reg(2'd0, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL cnt_div256 got=%h exp=01", d); end
        step(344);
        rd_reg(2'd0, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL cnt_div600 got=%h exp=02", d); end
        rd_reg(2'd1, d);
        total++; if (d !== 8'h25) begin bad++; $display("FAIL cnt_n600 got=%h exp=25", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        setup_overflow();
        step(13);
        rd_reg(2'd1, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL ovf_pre got=%h exp=FF", d); end
        step(1);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h00 || irq_timer !== 1'b0) begin bad++; $display("FAIL ovf_first got=%h/%b exp=00/0", d, irq_timer); end
        step(3);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h00 || irq_timer !== 1'b0) begin bad++; $display("FAIL ovf_last got=%h/%b exp=00/0", d, irq_timer); end
        step(1);
        rd_reg(2'd1, d);
        total++; if (d !== 8'hAB || irq_timer !== 1'b1) begin bad++; $display("FAIL ovf_reload got=%h/%b exp=AB/1", d, irq_timer); end
        step(1);
        rd_reg(2'd1, d);
        total++; if (d !== 8'hAB || irq_timer !== 1'b0) begin bad++; $display("FAIL ovf_after got=%h/%b exp=AB/0", d, irq_timer); end
        step(11);
        rd_reg(2'd1, d);
        total++; if (d !== 8'hAC) begin bad++; $display("FAIL ovf_next got=%h exp=AC", d); end
    endtask

    task automatic test_cancel();
        logic [7:0] d;
        int         irqs;
        irqs = 0;
        setup_overflow();
        step(15);
        wr_reg(2'd1, 8'h42);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h42) begin bad++; $display("FAIL cancel_wr got=%h exp=42", d); end
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (irq_timer === 1'b1) irqs++;
        end
        rd_reg(2'd1, d);
        total++; if (d !== 8'h42 || irqs != 0) begin bad++; $display("FAIL cancel_hold got=%h/%0d exp=42/0", d, irqs); end
        step(8);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h43) begin bad++; $display("FAIL cancel_next got=%h exp=43", d); end
    endtask

    task automatic test_reload_write();
        logic [7:0] d;
        setup_overflow();
        step(18);
        total++; if (irq_timer !== 1'b1) begin bad++; $display("FAIL rl_irq got=%b exp=1", irq_timer); end
        wr_reg(2'd1, 8'h42);
        rd_reg(2'd1, d);
        total++; if (d !== 8'hAB) begin bad++; $display("FAIL rl_tima_wr got=%h exp=AB", d); end
        setup_overflow();
        step(18);
        wr_reg(2'd2, 8'h10);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h10) begin bad++; $display("FAIL rl_tma_wr got=%h exp=10", d); end
        rd_reg(2'd2, d);
        total++; if (d !== 8'h10) begin bad++; $display("FAIL rl_tma_reg got=%h exp=10", d); end
    endtask

    task automatic test_div_glitch();
        logic [7:0] d;
        do_reset();
        wr_reg(2'd3, 8'h05);
        step(8);
        wr_reg(2'd0, 8'h5A);
        rd_reg(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL dg_div got=%h exp=00", d); end
        rd_reg(2'd1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL dg_pre got=%h exp=00", d); end
        step(1);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL dg_inc got=%h exp=01", d); end
        step(16);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL dg_next got=%h exp=02", d); end
    endtask

    task automatic test_tac_glitch();
        logic [7:0] d;
        do_reset();
        wr_reg(2'd3, 8'h07);
        step(129);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL tg_rise got=%h exp=00", d); end
        wr_reg(2'd3, 8'h03);
        step(1);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL tg_inc got=%h exp=01", d); end
        total++; if (div_tap !== 4'b0100) begin bad++; $display("FAIL tg_tap got=%b exp=0100", div_tap); end
        step(68);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL tg_hold got=%h exp=01", d); end
        rd_reg(2'd3, d);
        total++; if (d !== 8'hFB) begin bad++; $display("FAIL tg_tac got=%h exp=FB", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        do_reset();
        wr_reg(2'd3, 8'h05);
        step(15);
        wr_reg(2'd1, 8'h80);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h80) begin bad++; $display("FAIL b2b_wr got=%h exp=80", d); end
        step(16);
        rd_reg(2'd1, d);
        total++; if (d !== 8'h81) begin bad++; $display("FAIL b2b_next got=%h exp=81", d); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        int         irqs;
        irqs = 0;
        setup_overflow();
        step(15);
        nreset = 1'b0;
        #1;
        rd_reg(2'd2, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL abort_tma got=%h exp=00", d); end
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (irq_timer === 1'b1) irqs++;
        end
        rd_reg(2'd1, d);
        total++; if (d !== 8'h00 || irqs != 0) begin bad++; $display("FAIL abort_seq got=%h/%0d exp=00/0", d, irqs); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_overflow();
        test_cancel();
        test_reload_write();
        test_div_glitch();
        test_tac_glitch();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
